// File: rtl/voice_scheduler_pkg.sv
// Shared types and default widths for the voice scheduler.
//   - fsm_state_t   : control FSM encodings
//   - voice_state_t : per-voice state (FREE=0, PLAYING=1, RELEASING=2)
//   - sel_kind_t    : outcome of the voice search
package voice_scheduler_pkg;

  localparam int unsigned DefNVoices   = 4;
  localparam int unsigned DefFcwWidth  = 24;
  localparam int unsigned DefNoteWidth = 7;
  localparam int unsigned DefAgeWidth  = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLookup  = 3'd1,
    StReset   = 3'd2,
    StFcw     = 3'd3,
    StStart   = 3'd4,
    StRelease = 3'd5
  } fsm_state_t;

  typedef enum logic [1:0] {
    VsFree      = 2'd0,
    VsPlaying   = 2'd1,
    VsReleasing = 2'd2
  } voice_state_t;

  typedef enum logic [2:0] {
    SelNone    = 3'd0,
    SelRetrig  = 3'd1,
    SelFree    = 3'd2,
    SelSteal   = 3'd3,
    SelRelease = 3'd4
  } sel_kind_t;

endpackage

// File: rtl/voice_select.sv
// Combinational voice search.
// Inputs : states, notes, ages (per voice), req_on, req_note.
// Outputs: target (voice index), kind (retrigger/free/steal/release/none).
// Note-on priority: retrigger a non-free voice holding the note, else lowest free voice,
// else the oldest voice (ties to lowest index). Note-off: a PLAYING voice holding the note.
module voice_select
  import voice_scheduler_pkg::*;
#(
  parameter int unsigned N_VOICES   = DefNVoices,
  parameter int unsigned NOTE_WIDTH = DefNoteWidth,
  parameter int unsigned AGE_WIDTH  = DefAgeWidth
) (
  input  voice_state_t [N_VOICES-1:0]                 states,
  input  logic         [N_VOICES-1:0][NOTE_WIDTH-1:0] notes,
  input  logic         [N_VOICES-1:0][AGE_WIDTH-1:0]  ages,
  input  logic                                        req_on,
  input  logic         [NOTE_WIDTH-1:0]               req_note,
  output logic         [$clog2(N_VOICES)-1:0]         target,
  output sel_kind_t                                   kind
);

  localparam int unsigned IdxW = $clog2(N_VOICES);

  logic            hit_found, free_found, rel_found;
  logic [IdxW-1:0] hit_idx, free_idx, rel_idx, old_idx;
  logic [AGE_WIDTH-1:0] old_age;

  always_comb begin
    hit_found  = 1'b0;
    free_found = 1'b0;
    rel_found  = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    rel_idx    = '0;
    old_idx    = '0;
    old_age    = ages[0];

    // Walk downwards so the last match written is the lowest index.
    for (int i = int'(N_VOICES) - 1; i >= 0; i--) begin
      if (states[i] != VsFree && notes[i] == req_note) begin
        hit_found = 1'b1;
        hit_idx   = IdxW'(i);
      end
      if (states[i] == VsFree) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
      if (states[i] == VsPlaying && notes[i] == req_note) begin
        rel_found = 1'b1;
        rel_idx   = IdxW'(i);
      end
    end

    // Strict compare keeps the lowest index on equal ages.
    for (int i = 1; i < int'(N_VOICES); i++) begin
      if (ages[i] > old_age) begin
        old_age = ages[i];
        old_idx = IdxW'(i);
      end
    end

    target = '0;
    kind   = SelNone;
    if (req_on) begin
      if (hit_found) begin
        target = hit_idx;
        kind   = SelRetrig;
      end else if (free_found) begin
        target = free_idx;
        kind   = SelFree;
      end else begin
        target = old_idx;
        kind   = SelSteal;
      end
    end else if (rel_found) begin
      target = rel_idx;
      kind   = SelRelease;
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Allocates note-on/note-off requests onto the synth voices and sequences the
// per-voice reset, FCW write, start and release strobes.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   req_valid/ready    : request handshake (ready only in IDLE)
//   req_on/note/fcw    : request payload
//   voice_done         : per-voice end-of-release pulse
//   fcw_data           : registered FCW bus shared by all voices
//   fcw_we, note_start, note_release, voice_rst : one-hot 1-cycle strobes
//   active_mask        : bit i set when voice i is not FREE
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int unsigned N_VOICES   = DefNVoices,
  parameter int unsigned FCW_WIDTH  = DefFcwWidth,
  parameter int unsigned NOTE_WIDTH = DefNoteWidth,
  parameter int unsigned AGE_WIDTH  = DefAgeWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_on,
  input  logic [NOTE_WIDTH-1:0] req_note,
  input  logic [FCW_WIDTH-1:0]  req_fcw,
  input  logic [N_VOICES-1:0]   voice_done,
  output logic [FCW_WIDTH-1:0]  fcw_data,
  output logic [N_VOICES-1:0]   fcw_we,
  output logic [N_VOICES-1:0]   note_start,
  output logic [N_VOICES-1:0]   note_release,
  output logic [N_VOICES-1:0]   voice_rst,
  output logic [N_VOICES-1:0]   active_mask
);

  localparam int unsigned IdxW = $clog2(N_VOICES);

  fsm_state_t                                 state_q;
  logic                                       req_on_q;
  logic         [NOTE_WIDTH-1:0]              req_note_q;
  logic         [FCW_WIDTH-1:0]               req_fcw_q;
  logic         [IdxW-1:0]                    target_q;
  voice_state_t [N_VOICES-1:0]                vstate_q;
  logic         [N_VOICES-1:0][NOTE_WIDTH-1:0] vnote_q;
  logic         [N_VOICES-1:0][AGE_WIDTH-1:0]  vage_q;

  logic      [IdxW-1:0] sel_target;
  sel_kind_t            sel_kind;

  voice_select #(
    .N_VOICES  (N_VOICES),
    .NOTE_WIDTH(NOTE_WIDTH),
    .AGE_WIDTH (AGE_WIDTH)
  ) u_voice_select (
    .states  (vstate_q),
    .notes   (vnote_q),
    .ages    (vage_q),
    .req_on  (req_on_q),
    .req_note(req_note_q),
    .target  (sel_target),
    .kind    (sel_kind)
  );

  function automatic logic [N_VOICES-1:0] onehot(input logic [IdxW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign req_ready = (state_q == StIdle);

  always_comb begin
    active_mask = '0;
    for (int i = 0; i < int'(N_VOICES); i++) begin
      active_mask[i] = (vstate_q[i] != VsFree);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_on_q     <= 1'b0;
      req_note_q   <= '0;
      req_fcw_q    <= '0;
      target_q     <= '0;
      fcw_data     <= '0;
      fcw_we       <= '0;
      note_start   <= '0;
      note_release <= '0;
      voice_rst    <= '0;
      for (int i = 0; i < int'(N_VOICES); i++) begin
        vstate_q[i] <= VsFree;
        vnote_q[i]  <= '0;
        vage_q[i]   <= '0;
      end
    end else begin
      // Strobes are single-cycle unless re-asserted by the state transition below.
      fcw_we       <= '0;
      note_start   <= '0;
      note_release <= '0;
      voice_rst    <= '0;

      for (int i = 0; i < int'(N_VOICES); i++) begin
        if (voice_done[i] && vstate_q[i] == VsReleasing) begin
          vstate_q[i] <= VsFree;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            req_on_q   <= req_on;
            req_note_q <= req_note;
            req_fcw_q  <= req_fcw;
            state_q    <= StLookup;
          end
        end
        StLookup: begin
          target_q <= sel_target;
          unique case (sel_kind)
            SelRetrig, SelFree: begin
              fcw_data <= req_fcw_q;
              fcw_we   <= onehot(sel_target);
              state_q  <= StFcw;
            end
            SelSteal: begin
              voice_rst <= onehot(sel_target);
              state_q   <= StReset;
            end
            SelRelease: begin
              note_release <= onehot(sel_target);
              state_q      <= StRelease;
            end
            default: state_q <= StIdle;
          endcase
        end
        StReset: begin
          fcw_data <= req_fcw_q;
          fcw_we   <= onehot(target_q);
          state_q  <= StFcw;
        end
        StFcw: begin
          note_start <= onehot(target_q);
          state_q    <= StStart;
        end
        StStart: begin
          // Written after the voice_done loop, so a same-cycle done loses to START.
          for (int i = 0; i < int'(N_VOICES); i++) begin
            if (IdxW'(i) == target_q) begin
              vstate_q[i] <= VsPlaying;
              vnote_q[i]  <= req_note_q;
              vage_q[i]   <= '0;
            end else if (vstate_q[i] != VsFree && vage_q[i] != '1) begin
              vage_q[i] <= vage_q[i] + 1'b1;
            end
          end
          state_q <= StIdle;
        end
        StRelease: begin
          vstate_q[target_q] <= VsReleasing;
          state_q            <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Allocates note-on/note-off requests from the CPU's memory-mapped note port onto the four synthesizer voices and sequences each voice's FCW write, start, release and reset strobes. The block sits between the MMIO store decode and the voice datapaths, so software issues notes without tracking which voice is free. Each voice is tracked as FREE, PLAYING or RELEASING. When all voices are busy, the oldest voice is stolen.

## Interface
- `N_VOICES`, 4: number of voices; the design is verified at 4 only.
- `FCW_WIDTH`, 24: frequency control word width.
- `NOTE_WIDTH`, 7: note ID width (MIDI number).
- `AGE_WIDTH`, 8: per-voice saturating age counter width.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  a request is present.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `req_on`  in  1  1 = note-on, 0 = note-off.
- `req_note`  in  NOTE_WIDTH  note ID.
- `req_fcw`  in  FCW_WIDTH  FCW for note-on; ignored for note-off.
- `voice_done`  in  N_VOICES  per-voice pulse meaning the envelope has finished releasing.
- `fcw_data`  out  FCW_WIDTH  registered FCW bus shared by all voices.
- `fcw_we`  out  N_VOICES  one-hot, 1-cycle FCW write strobe.
- `note_start`  out  N_VOICES  one-hot, 1-cycle start strobe.
- `note_release`  out  N_VOICES  one-hot, 1-cycle release strobe.
- `voice_rst`  out  N_VOICES  one-hot, 1-cycle reset strobe; used only when a voice is stolen.
- `active_mask`  out  N_VOICES  bit i is 1 when voice i is not FREE.

## Operation
Per-voice state:
- Voice state (FREE, PLAYING or RELEASING), stored note ID, and age counter.

Control FSM: IDLE, LOOKUP, RESET, FCW, START, RELEASE.
- IDLE: a request is accepted and latched (`req_on`, `req_note`, `req_fcw`); go to LOOKUP.
- LOOKUP, note-on: the target voice is chosen by the first rule that applies.
  1. Retrigger: lowest-index voice not FREE whose stored note equals `req_note`; go to FCW.
  2. Free: lowest-index FREE voice; go to FCW.
  3. Steal: voice with the maximum age, ties to the lowest index; go to RESET.
- LOOKUP, note-off:
  - A PLAYING voice with the matching note: go to RELEASE.
  - Otherwise the request is dropped: go to IDLE.
- RESET: pulse `voice_rst[t]`; go to FCW.
- FCW: `fcw_data` = latched FCW; pulse `fcw_we[t]`; go to START.
- START: pulse `note_start[t]`. Voice t becomes PLAYING, its stored note is set to `req_note`, and its age is cleared to 0. Every other voice that is not FREE increments its age, saturating at 2^AGE_WIDTH−1. Go to IDLE.
- RELEASE: pulse `note_release[t]`; voice t becomes RELEASING; go to IDLE.

`voice_done[i]` is sampled every cycle, in any FSM state.
- Voice i in RELEASING: it becomes FREE.
- Voice i in any other state: ignored.
- Same cycle as a START update to voice i: the START update wins and the voice is PLAYING.

A note-off for a voice that is already RELEASING is dropped. At most one voice holds a given note, because a repeated note-on retriggers the existing voice.

## Timing
Reset values (`rst_n` low at a clock edge):
- FSM is IDLE.
- All voices FREE, ages 0, stored notes 0.
- `fcw_data` = 0.
- All strobes 0; `active_mask` = 0.
- `req_ready` = 1 from the first cycle after reset.
- A reset in the middle of a sequence aborts it; no further strobes are issued.

Request latencies (accept edge = cycle 0):
- Note-on to a free or retriggered voice: LOOKUP in cycle 1, `fcw_we` in cycle 2, `note_start` in cycle 3, `req_ready` high again in cycle 4. Throughput is 1 request per 4 cycles.
- Stolen voice: `voice_rst` in cycle 2, `fcw_we` in cycle 3, `note_start` in cycle 4, ready in cycle 5.
- Note-off: `note_release` in cycle 2, ready in cycle 3. A dropped note-off is ready in cycle 2.

Output behaviour:
- `fcw_data` holds its value until the next FCW state.
- All strobes are registered outputs, at most one bit set, never two strobe types in the same cycle.
- `active_mask` reflects the state registers, so it updates the cycle after START, RELEASE or `voice_done`.

## Structure
- Shared header `VoiceSched.vh`, alongside `Opcode.vh`: FSM state encodings, voice state encodings (FREE=0, PLAYING=1, RELEASING=2), and default widths.
- Sub-module `voice_select`: combinational search that takes the voice states, stored notes, ages and requested note, and returns the target index plus kind (retrigger, free, steal, release, none).
- `voice_scheduler` holds the FSM, per-voice registers and output registers.

## Test plan
- Reset, then note-on (note 60, FCW 0x001234):
  - Cycle 2: `fcw_we`=0001, `fcw_data`=0x001234.
  - Cycle 3: `note_start`=0001.
  - Then `active_mask`=0001.
- Four note-ons (notes 60–63), then note-on note 64:
  - `voice_rst`=0001, `fcw_we`=0001, `note_start`=0001 on consecutive cycles; voice 0 now holds note 64.
- Note-on 60, then note-on 60 with FCW 0x000ABC:
  - Retrigger of voice 0: no `voice_rst`, `fcw_we`=0001 with `fcw_data`=0x000ABC, `active_mask` stays 0001.
- Note-on 60, note-off 60, then `voice_done`=0001:
  - `note_release`=0001 at cycle 2; voice 0 RELEASING; after `voice_done`, `active_mask`=0000.
- Note-off 70 with no voices active:
  - No strobes; `req_ready` high again 2 cycles after accept.
- `rst_n` low during the FCW state of a note-on:
  - No `note_start`; all outputs at reset values; `req_ready`=1 after release.
